psx_host_port: RTL and testbench

//   Host (console) side of the PSX/PS2 controller and memory-card serial link: drives SEL, CLK and CMD,

---
 rtl/psx_host_port.sv | 221 ++++++++++++++++++++++
 tb/tb_psx_host_port.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_host_port.sv
// Host side of the PSX controller / memory-card serial link.
// Drives SEL, CLK and CMD, samples DAT and watches for the device ACK pulse.
// Each byte request becomes one full-duplex 8-bit transfer, LSB first,
// followed by an ACK window.
module psx_host_port #(
  parameter int CLOCK_MHZ      = 25,
  parameter int BIT_HALF_US    = 2,
  parameter int SEL_SETUP_US   = 20,
  parameter int ACK_TIMEOUT_US = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic       PSX_clk,
  output logic       PSX_sel,
  output logic       PSX_cmd,
  input  logic       PSX_dat,
  input  logic       PSX_ack,
  input  logic       host_select,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       ready,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_ack
);

  // Terminal counts: the timer restarts at 0 on every state entry, so a
  // phase of N cycles ends when the timer shows N-1.
  localparam logic [15:0] HALF_LAST    = 16'(CLOCK_MHZ * BIT_HALF_US - 1);
  localparam logic [15:0] SETUP_LAST   = 16'(CLOCK_MHZ * SEL_SETUP_US - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(CLOCK_MHZ * ACK_TIMEOUT_US - 1);
  localparam logic [15:0] TIMER_MAX    = 16'hFFFF;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEL_SETUP = 3'd1;
  localparam logic [2:0] ST_READY     = 3'd2;
  localparam logic [2:0] ST_CLK_LOW   = 3'd3;
  localparam logic [2:0] ST_CLK_HIGH  = 3'd4;
  localparam logic [2:0] ST_ACK_WAIT  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        ack_seen_q, ack_seen_d;
  logic        psx_clk_q, psx_clk_d;
  logic        psx_sel_q, psx_sel_d;
  logic        psx_cmd_q, psx_cmd_d;
  logic        ready_q, ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_strobe_q, rx_strobe_d;
  logic        rx_ack_q, rx_ack_d;
  logic        dat_s1_q, dat_s2_q;
  logic        ack_s1_q, ack_s2_q;

  // Two-flop synchronizers for the asynchronous device lines, preset to the idle (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      ack_s1_q <= 1'b1;
      ack_s2_q <= 1'b1;
    end else begin
      dat_s1_q <= PSX_dat;
      dat_s2_q <= dat_s1_q;
      ack_s1_q <= PSX_ack;
      ack_s2_q <= ack_s1_q;
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    ack_seen_d  = ack_seen_q;
    rx_data_d   = rx_data_q;
    rx_ack_d    = rx_ack_q;
    rx_strobe_d = 1'b0;
    timer_d     = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (host_select) begin
          state_d = ST_SEL_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEL_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_SEL_SETUP;
        end
      end
      ST_READY: begin
        // ready_q gates acceptance so the cycle right after rx_strobe is not ready yet.
        if (tx_strobe && ready_q) begin
          tx_d    = tx_data;
          bit_d   = 3'd0;
          state_d = ST_CLK_LOW;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_CLK_LOW: begin
        if (timer_q == HALF_LAST) begin
          state_d = ST_CLK_HIGH;
        end else begin
          state_d = ST_CLK_LOW;
        end
      end
      ST_CLK_HIGH: begin
        if (timer_q == HALF_LAST) begin
          // Sample DAT as late as possible in the high phase; LSB arrives first.
          rx_sh_d = {dat_s2_q, rx_sh_q[7:1]};
          if (bit_q == 3'd7) begin
            ack_seen_d = 1'b0;
            state_d    = ST_ACK_WAIT;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_CLK_LOW;
          end
        end else begin
          state_d = ST_CLK_HIGH;
        end
      end
      ST_ACK_WAIT: begin
        if (!ack_s2_q) begin
          ack_seen_d = 1'b1;
        end else begin
          ack_seen_d = ack_seen_q;
        end
        if ((ack_seen_q && ack_s2_q) || (timer_q == TIMEOUT_LAST)) begin
          state_d     = ST_READY;
          rx_strobe_d = 1'b1;
          rx_data_d   = rx_sh_q;
          rx_ack_d    = ack_seen_q | ~ack_s2_q;
        end else begin
          state_d = ST_ACK_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping host_select ends the packet from any state; an in-flight byte is discarded.
    if (!host_select) begin
      state_d     = ST_IDLE;
      rx_strobe_d = 1'b0;
      rx_data_d   = rx_data_q;
      rx_ack_d    = rx_ack_q;
    end else begin
      state_d = state_d;
    end

    if (state_d != state_q) begin
      timer_d = 16'd0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = timer_q;
    end

    // Bus outputs follow the state being entered so they change on the same edge.
    psx_sel_d = (state_d == ST_IDLE);
    psx_clk_d = (state_d != ST_CLK_LOW);
    if ((state_d == ST_CLK_LOW) || (state_d == ST_CLK_HIGH)) begin
      psx_cmd_d = tx_d[bit_d];
    end else begin
      psx_cmd_d = 1'b1;
    end
    ready_d = (state_d == ST_READY) && (state_q != ST_ACK_WAIT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= 16'd0;
      bit_q       <= 3'd0;
      tx_q        <= 8'h00;
      rx_sh_q     <= 8'h00;
      ack_seen_q  <= 1'b0;
      psx_clk_q   <= 1'b1;
      psx_sel_q   <= 1'b1;
      psx_cmd_q   <= 1'b1;
      ready_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      rx_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      ack_seen_q  <= ack_seen_d;
      psx_clk_q   <= psx_clk_d;
      psx_sel_q   <= psx_sel_d;
      psx_cmd_q   <= psx_cmd_d;
      ready_q     <= ready_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      rx_ack_q    <= rx_ack_d;
    end
  end

  assign PSX_clk   = psx_clk_q;
  assign PSX_sel   = psx_sel_q;
  assign PSX_cmd   = psx_cmd_q;
  assign ready     = ready_q;
  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign rx_ack    = rx_ack_q;

endmodule

// File: tb/tb_psx_host_port.sv
// Bench for psx_host_port: a simple PSX device model answers the host, a
// scoreboard queue holds the expected {ack, data} of each launched byte.
module tb_psx_host_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       PSX_clk, PSX_sel, PSX_cmd;
  logic       PSX_dat = 1'b1;
  logic       PSX_ack = 1'b1;
  logic       host_select;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_ack;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  psx_host_port dut (
    .clk        (clk),
    .reset      (reset),
    .PSX_clk    (PSX_clk),
    .PSX_sel    (PSX_sel),
    .PSX_cmd    (PSX_cmd),
    .PSX_dat    (PSX_dat),
    .PSX_ack    (PSX_ack),
    .host_select(host_select),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe),
    .ready      (ready),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .rx_ack     (rx_ack)
  );

  always #5 clk = ~clk;

  // Cycle counter: after posedge k it reads k.
  always @(posedge clk) cyc <= cyc + 1;

  // Device model: drives DAT on CLK falls, samples CMD on rises, ACK pulse after the 8th rise.
  logic       dev_dat_en = 1'b0;
  logic       dev_ack_en = 1'b0;
  logic [7:0] dev_reply = 8'h00;
  logic [7:0] cmd_seen = 8'h00;
  logic       prev_clk = 1'b1;
  int rise_cnt = 0;
  int total_falls = 0;
  int ack_dly = -1;
  int ack_len = 0;
  int last_rise_cyc = 0;
  int fall_cyc[$];
  int rise_cyc[$];

  always @(negedge clk) begin
    if (PSX_sel !== 1'b0) begin
      rise_cnt = 0;
      ack_dly  = -1;
      ack_len  = 0;
      PSX_dat  = 1'b1;
      PSX_ack  = 1'b1;
    end else begin
      if (prev_clk === 1'b1 && PSX_clk === 1'b0) begin
        if (rise_cnt == 8) rise_cnt = 0;
        if (rise_cnt == 0) begin
          fall_cyc.delete();
          rise_cyc.delete();
          cmd_seen = 8'h00;
        end
        fall_cyc.push_back(cyc);
        total_falls++;
        PSX_dat = dev_dat_en ? dev_reply[3'(rise_cnt)] : 1'b1;
      end else if (prev_clk === 1'b0 && PSX_clk === 1'b1) begin
        cmd_seen[3'(rise_cnt)] = PSX_cmd;
        rise_cyc.push_back(cyc);
        rise_cnt++;
        if (rise_cnt == 8) begin
          last_rise_cyc = cyc;
          if (dev_ack_en) ack_dly = 200;
        end
      end
      if (ack_dly > 0) begin
        ack_dly--;
      end else if (ack_dly == 0) begin
        PSX_ack = 1'b0;
        ack_len = 75;
        ack_dly = -1;
      end else if (ack_len > 0) begin
        ack_len--;
        if (ack_len == 0) PSX_ack = 1'b1;
      end
    end
    prev_clk = PSX_clk;
  end

  // Output monitor: counts rx_strobe pulses and watches SEL during back-to-back.
  int   strobe_cnt = 0;
  int   strobe_cyc = 0;
  logic strobe_ready = 1'b0;
  logic sel_watch = 1'b0;
  logic sel_went_high = 1'b0;

  always @(negedge clk) begin
    if (rx_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_cyc   = cyc;
      strobe_ready = ready;
    end
    if (sel_watch && PSX_sel !== 1'b0) sel_went_high = 1'b1;
  end

  logic [8:0] exp_q[$];
  logic [8:0] last_exp = 9'h000;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_strobes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (strobe_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_bit_low(input int bitn, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rise_cnt == bitn && PSX_clk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_pop();
    logic [8:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: rx_strobe with no expected entry, got %h", rx_data);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      tests_run++;
      if ({rx_ack, rx_data} !== e) begin
        tests_failed++;
        $display("FAIL rx_result: got ack=%b data=%h expected ack=%b data=%h",
                 rx_ack, rx_data, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; host_select = 1'b0; tx_strobe = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    tests_run++;
    if ({PSX_clk, PSX_sel, PSX_cmd, ready, rx_strobe, rx_ack, rx_data} !== 14'b111000_00000000) begin
      tests_failed++;
      $display("FAIL reset_state: got clk/sel/cmd/rdy/stb/ack=%b%b%b%b%b%b data=%h expected 111000 00",
               PSX_clk, PSX_sel, PSX_cmd, ready, rx_strobe, rx_ack, rx_data);
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_select();
    int c0;
    bit ok;
    tests_run++;
    if (PSX_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL select_idle: PSX_sel=%b expected 1", PSX_sel);
    end
    host_select = 1'b1;
    c0 = cyc;
    tick();
    tests_run++;
    if (PSX_sel !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL select_assert: PSX_sel=%b ready=%b expected 0 0", PSX_sel, ready);
    end
    repeat (10) tick();
    tx_data = 8'hAA; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    wait_ready(1000, ok);
    tests_run++;
    if (!ok || (cyc - c0) != 501) begin
      tests_failed++;
      $display("FAIL select_setup_time: ready after %0d cycles (seen=%b) expected 501", cyc - c0, ok);
    end
    tests_run++;
    if (total_falls != 0 || PSX_clk !== 1'b1) begin
      tests_failed++;
      $display("FAIL setup_strobe_ignored: falls=%0d PSX_clk=%b expected 0 1", total_falls, PSX_clk);
    end
  endtask

  task automatic test_byte_ack();
    int c0, s0, bad;
    bit ok;
    dev_reply = 8'h41; dev_dat_en = 1'b1; dev_ack_en = 1'b1;
    s0 = strobe_cnt;
    exp_q.push_back({1'b1, 8'h41});
    tx_data = 8'h01; tx_strobe = 1'b1; c0 = cyc;
    tick();
    tx_strobe = 1'b0;
    tests_run++;
    if (ready !== 1'b0 || PSX_clk !== 1'b0) begin
      tests_failed++;
      $display("FAIL byte_start: ready=%b PSX_clk=%b expected 0 0", ready, PSX_clk);
    end
    wait_strobes(s0 + 1, 3000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL byte_ack_timeout: no rx_strobe, got count %0d expected %0d", strobe_cnt, s0 + 1);
    end
    tests_run++;
    if (fall_cyc.size() != 8 || rise_cyc.size() != 8) begin
      tests_failed++;
      $display("FAIL byte_clk_count: falls=%0d rises=%0d expected 8 8", fall_cyc.size(), rise_cyc.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (rise_cyc[i] - fall_cyc[i] != 50) bad++;
        if (i > 0 && fall_cyc[i] - fall_cyc[i-1] != 100) bad++;
      end
      tests_run++;
      if (bad != 0 || fall_cyc[0] != c0 + 1) begin
        tests_failed++;
        $display("FAIL byte_clk_timing: bad=%0d first_fall=%0d expected 0 and %0d", bad, fall_cyc[0], c0 + 1);
      end
    end
    tests_run++;
    if (cmd_seen !== 8'h01) begin
      tests_failed++;
      $display("FAIL byte_cmd_bits: got %h expected 01", cmd_seen);
    end
    check_pop();
    tests_run++;
    if (strobe_ready !== 1'b0 || ready !== 1'b1 || cyc != strobe_cyc + 1) begin
      tests_failed++;
      $display("FAIL byte_ready_return: at strobe=%b after=%b dcyc=%0d expected 0 1 1",
               strobe_ready, ready, cyc - strobe_cyc);
    end
    repeat (5) tick();
    tests_run++;
    if (strobe_cnt != s0 + 1) begin
      tests_failed++;
      $display("FAIL byte_single_strobe: got %0d strobes expected 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_no_ack();
    int s0;
    bit ok;
    dev_dat_en = 1'b0; dev_ack_en = 1'b0;
    s0 = strobe_cnt;
    exp_q.push_back({1'b0, 8'hFF});
    tx_data = 8'h42; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    wait_strobes(s0 + 1, 5000, ok);
    tests_run++;
    if (!ok || strobe_cyc - last_rise_cyc != 2550) begin
      tests_failed++;
      $display("FAIL noack_timeout: strobe %0d cycles after 8th rise (seen=%b) expected 2550",
               strobe_cyc - last_rise_cyc, ok);
    end
    tests_run++;
    if (cmd_seen !== 8'h42) begin
      tests_failed++;
      $display("FAIL noack_cmd_bits: got %h expected 42", cmd_seen);
    end
    check_pop();
    tests_run++;
    if (strobe_ready !== 1'b0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL noack_ready: at strobe=%b next=%b expected 0 1", strobe_ready, ready);
    end
  endtask

  task automatic test_back_to_back();
    int s0, c1;
    bit ok;
    dev_reply = 8'h41; dev_dat_en = 1'b1; dev_ack_en = 1'b1;
    sel_watch = 1'b1; sel_went_high = 1'b0;
    s0 = strobe_cnt;
    exp_q.push_back({1'b1, 8'h41});
    tx_data = 8'h01; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    repeat (300) tick();
    tx_data = 8'h99; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    wait_strobes(s0 + 1, 3000, ok);
    tests_run++;
    if (!ok || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: strobe seen=%b ready=%b expected 1 1", ok, ready);
    end
    tests_run++;
    if (cmd_seen !== 8'h01 || fall_cyc.size() != 8) begin
      tests_failed++;
      $display("FAIL b2b_midbyte_ignored: cmd=%h falls=%0d expected 01 8", cmd_seen, fall_cyc.size());
    end
    check_pop();
    dev_reply = 8'h5A;
    exp_q.push_back({1'b1, 8'h5A});
    tx_data = 8'h42; tx_strobe = 1'b1; c1 = cyc;
    tick();
    tx_strobe = 1'b0;
    tests_run++;
    if (PSX_clk !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: PSX_clk=%b ready=%b expected 0 0", PSX_clk, ready);
    end
    wait_strobes(s0 + 2, 3000, ok);
    tests_run++;
    if (!ok || cmd_seen !== 8'h42 || fall_cyc[0] != c1 + 1) begin
      tests_failed++;
      $display("FAIL b2b_second: seen=%b cmd=%h first_fall=%0d expected 1 42 %0d", ok, cmd_seen, fall_cyc[0], c1 + 1);
    end
    check_pop();
    repeat (3) tick();
    tests_run++;
    if (sel_went_high !== 1'b0 || strobe_cnt != s0 + 2) begin
      tests_failed++;
      $display("FAIL b2b_sel_held: sel_high=%b strobes=%0d expected 0 2", sel_went_high, strobe_cnt - s0);
    end
    sel_watch = 1'b0;
  endtask

  task automatic test_abort();
    int s0, c0;
    bit ok;
    dev_reply = 8'h00; dev_dat_en = 1'b1; dev_ack_en = 1'b1;
    s0 = strobe_cnt;
    tx_data = 8'h55; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    wait_bit_low(5, 2000, ok);
    tests_run++;
    if (!ok || PSX_cmd !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reach_bit5: seen=%b PSX_cmd=%b expected 1 0", ok, PSX_cmd);
    end
    host_select = 1'b0;
    tick();
    tests_run++;
    if ({PSX_clk, PSX_sel, PSX_cmd, ready} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL abort_outputs: clk/sel/cmd/rdy=%b%b%b%b expected 1110", PSX_clk, PSX_sel, PSX_cmd, ready);
    end
    repeat (3000) tick();
    tests_run++;
    if (strobe_cnt != s0 || {rx_ack, rx_data} !== last_exp) begin
      tests_failed++;
      $display("FAIL abort_retain: strobes=%0d ack=%b data=%h expected 0 %b %h",
               strobe_cnt - s0, rx_ack, rx_data, last_exp[8], last_exp[7:0]);
    end
    host_select = 1'b1; c0 = cyc;
    wait_ready(1000, ok);
    tests_run++;
    if (!ok || (cyc - c0) != 501) begin
      tests_failed++;
      $display("FAIL abort_reselect: ready after %0d cycles (seen=%b) expected 501", cyc - c0, ok);
    end
  endtask

  task automatic test_reset_mid_byte();
    int s0;
    bit ok;
    s0 = strobe_cnt;
    tx_data = 8'hA5; tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    wait_bit_low(3, 2000, ok);
    tests_run++;
    if (!ok || PSX_cmd !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_reach_bit3: seen=%b PSX_cmd=%b expected 1 0", ok, PSX_cmd);
    end
    reset = 1'b0;
    host_select = 1'b0;
    #1;
    tests_run++;
    if ({PSX_clk, PSX_sel, PSX_cmd, ready, rx_strobe, rx_ack, rx_data} !== 14'b111000_00000000) begin
      tests_failed++;
      $display("FAIL rst_midbyte_outputs: clk/sel/cmd/rdy/stb/ack=%b%b%b%b%b%b data=%h expected 111000 00",
               PSX_clk, PSX_sel, PSX_cmd, ready, rx_strobe, rx_ack, rx_data);
    end
    repeat (5) tick();
    reset = 1'b1;
    repeat (3000) tick();
    tests_run++;
    if (strobe_cnt != s0 || PSX_sel !== 1'b1 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_strobe: strobes=%0d sel=%b ready=%b expected 0 1 0", strobe_cnt - s0, PSX_sel, ready);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_byte_ack();
    test_no_ack();
    test_back_to_back();
    test_abort();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
